// File: rtl/ex_stage_if.sv
// ID-to-EX handshake and decoded-instruction bus of the five-stage MIPS core.
// master = ID stage (producer), slave = EX stage (consumer).
interface ex_stage_if;
   logic        ds_to_es_valid;
   logic        es_allowin;
   logic [11:0] ds_alu_op;
   logic [31:0] ds_src1;
   logic [31:0] ds_src2;
   logic [31:0] ds_rt_value;
   logic [4:0]  ds_dest;
   logic        ds_load;
   logic        ds_store;
   logic        ds_ovf_chk;
   logic [31:0] ds_pc;

   modport master (
      output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rt_value,
             ds_dest, ds_load, ds_store, ds_ovf_chk, ds_pc,
      input  es_allowin
   );

   modport slave (
      input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_rt_value,
             ds_dest, ds_load, ds_store, ds_ovf_chk, ds_pc,
      output es_allowin
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: one-entry pipeline register, one-hot ALU, data-SRAM request and forwarding view.
// Optional macro EX_OVF_EN enables signed-overflow exceptions for add/sub with ds_ovf_chk.

module ex_alu (
   input  logic [11:0]        alu_op,
   input  logic signed [31:0] alu_src1,
   input  logic signed [31:0] alu_src2,
   output logic [31:0]        alu_result
);
   localparam int ALUOP_ADD  = 0;
   localparam int ALUOP_SUB  = 1;
   localparam int ALUOP_SLT  = 2;
   localparam int ALUOP_SLTU = 3;
   localparam int ALUOP_AND  = 4;
   localparam int ALUOP_NOR  = 5;
   localparam int ALUOP_OR   = 6;
   localparam int ALUOP_XOR  = 7;
   localparam int ALUOP_SLL  = 8;
   localparam int ALUOP_SRL  = 9;
   localparam int ALUOP_SRA  = 10;
   localparam int ALUOP_LUI  = 11;

   logic signed [31:0] add_res;
   logic signed [31:0] sub_res;
   logic signed [31:0] sra_res;
   logic [31:0]        slt_res;
   logic [31:0]        sltu_res;
   logic [31:0]        sll_res;
   logic [31:0]        srl_res;
   logic [31:0]        lui_res;
   logic [4:0]         sa;

   // Shifts take the amount from src1 and shift src2, as ID muxes sa/rs into src1.
   assign sa       = alu_src1[4:0];
   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = {31'b0, (alu_src1 < alu_src2)};
   assign sltu_res = {31'b0, ($unsigned(alu_src1) < $unsigned(alu_src2))};
   assign sll_res  = $unsigned(alu_src2) << sa;
   assign srl_res  = $unsigned(alu_src2) >> sa;
   assign sra_res  = alu_src2 >>> sa;
   assign lui_res  = {alu_src2[15:0], 16'h0000};

   // One-hot select: an all-zero op yields zero.
   assign alu_result = ({32{alu_op[ALUOP_ADD]}}  & add_res)
                     | ({32{alu_op[ALUOP_SUB]}}  & sub_res)
                     | ({32{alu_op[ALUOP_SLT]}}  & slt_res)
                     | ({32{alu_op[ALUOP_SLTU]}} & sltu_res)
                     | ({32{alu_op[ALUOP_AND]}}  & (alu_src1 & alu_src2))
                     | ({32{alu_op[ALUOP_NOR]}}  & ~(alu_src1 | alu_src2))
                     | ({32{alu_op[ALUOP_OR]}}   & (alu_src1 | alu_src2))
                     | ({32{alu_op[ALUOP_XOR]}}  & (alu_src1 ^ alu_src2))
                     | ({32{alu_op[ALUOP_SLL]}}  & sll_res)
                     | ({32{alu_op[ALUOP_SRL]}}  & srl_res)
                     | ({32{alu_op[ALUOP_SRA]}}  & sra_res)
                     | ({32{alu_op[ALUOP_LUI]}}  & lui_res);
endmodule

module ex_stage (
   input  logic             clk,
   input  logic             resetn,
   ex_stage_if.slave        ds,
   input  logic             ms_allowin,
   output logic             es_to_ms_valid,
   output logic [31:0]      es_pc,
   output logic [31:0]      es_result,
   output logic [4:0]       es_dest,
   output logic             es_load,
   output logic             es_ex,
   output logic             data_sram_en,
   output logic [3:0]       data_sram_wen,
   output logic [31:0]      data_sram_addr,
   output logic [31:0]      data_sram_wdata,
   output logic             es_fwd_valid,
   output logic [4:0]       es_fwd_dest,
   output logic [31:0]      es_fwd_data,
   output logic             es_fwd_is_load
);
   logic               vld_p1;
   logic [11:0]        op_p1;
   logic signed [31:0] src1_p1;
   logic signed [31:0] src2_p1;
   logic [31:0]        rt_p1;
   logic [4:0]         dest_p1;
   logic               load_p1;
   logic               store_p1;
   logic [31:0]        pc_p1;
   logic               es_ready_go;
   logic               allowin;
   logic               mem_go;
   logic [31:0]        alu_res;

   assign es_ready_go   = 1'b1;
   assign allowin       = !vld_p1 || (es_ready_go && ms_allowin);
   assign ds.es_allowin = allowin;

   // ID -> EX boundary: valid follows allowin, payload loads only on a real handoff.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_p1 <= 1'b0;
      end else if (allowin) begin
         vld_p1 <= ds.ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_p1    <= '0;
         src1_p1  <= '0;
         src2_p1  <= '0;
         rt_p1    <= '0;
         dest_p1  <= '0;
         load_p1  <= 1'b0;
         store_p1 <= 1'b0;
         pc_p1    <= '0;
      end else if (ds.ds_to_es_valid && allowin) begin
         op_p1    <= ds.ds_alu_op;
         src1_p1  <= ds.ds_src1;
         src2_p1  <= ds.ds_src2;
         rt_p1    <= ds.ds_rt_value;
         dest_p1  <= ds.ds_dest;
         load_p1  <= ds.ds_load;
         store_p1 <= ds.ds_store;
         pc_p1    <= ds.ds_pc;
      end
   end

   ex_alu u_ex_alu (
      .alu_op     (op_p1),
      .alu_src1   (src1_p1),
      .alu_src2   (src2_p1),
      .alu_result (alu_res)
   );

`ifdef EX_OVF_EN
   localparam int OVF_ADD = 0;
   localparam int OVF_SUB = 1;

   logic ovf_chk_p1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ovf_chk_p1 <= 1'b0;
      end else if (ds.ds_to_es_valid && allowin) begin
         ovf_chk_p1 <= ds.ds_ovf_chk;
      end
   end

   function automatic logic signed_ovf(input logic [11:0] op,
                                       input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input logic [31:0] r);
      if (op[OVF_ADD]) return (a[31] == b[31]) && (r[31] != a[31]);
      else if (op[OVF_SUB]) return (a[31] != b[31]) && (r[31] != a[31]);
      else return 1'b0;
   endfunction

   assign es_ex = vld_p1 && ovf_chk_p1 && signed_ovf(op_p1, src1_p1, src2_p1, alu_res);
`else
   assign es_ex = 1'b0;
`endif

   assign es_to_ms_valid = vld_p1 && es_ready_go;
   assign es_pc          = pc_p1;
   assign es_result      = alu_res;
   assign es_dest        = es_ex ? 5'd0 : dest_p1;
   assign es_load        = load_p1;

   // The request fires only in the cycle MEM accepts, so a stalled access is issued exactly once.
   assign mem_go          = vld_p1 && ms_allowin && (load_p1 || store_p1) && !es_ex;
   assign data_sram_en    = mem_go;
   assign data_sram_wen   = (mem_go && store_p1) ? 4'hf : 4'h0;
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rt_p1;

   assign es_fwd_valid   = vld_p1 && (es_dest != 5'd0);
   assign es_fwd_dest    = es_dest;
   assign es_fwd_data    = alu_res;
   assign es_fwd_is_load = es_fwd_valid && load_p1;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus a randomized stream checked against a transaction model.
module tb_ex_stage;
   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rt;
      logic [4:0]  dest;
      bit          ld;
      bit          st;
      bit          ovf;
      logic [31:0] pc;
   } instr_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_pc, es_result;
   logic [4:0]  es_dest;
   logic        es_load, es_ex;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        es_fwd_valid;
   logic [4:0]  es_fwd_dest;
   logic [31:0] es_fwd_data;
   logic        es_fwd_is_load;

   int n_cmp = 0;
   int n_bad = 0;

   ex_stage_if bus ();

   ex_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ds              (bus),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_pc           (es_pc),
      .es_result       (es_result),
      .es_dest         (es_dest),
      .es_load         (es_load),
      .es_ex           (es_ex),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .es_fwd_valid    (es_fwd_valid),
      .es_fwd_dest     (es_fwd_dest),
      .es_fwd_data     (es_fwd_data),
      .es_fwd_is_load  (es_fwd_is_load)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference ALU from the MIPS instruction semantics (op index = ALUOP_* bit).
   function automatic logic [31:0] alu_ref(input instr_t i);
      logic signed [31:0] sa, sb;
      sa = i.a;
      sb = i.b;
      case (i.op)
         0:  return i.a + i.b;
         1:  return i.a - i.b;
         2:  return (sa < sb) ? 32'd1 : 32'd0;
         3:  return (i.a < i.b) ? 32'd1 : 32'd0;
         4:  return i.a & i.b;
         5:  return ~(i.a | i.b);
         6:  return i.a | i.b;
         7:  return i.a ^ i.b;
         8:  return i.b << i.a[4:0];
         9:  return i.b >> i.a[4:0];
         10: return sb >>> i.a[4:0];
         11: return {i.b[15:0], 16'h0};
         default: return 32'h0;
      endcase
   endfunction

   // Exception expected only when the check is requested and the true sum/difference leaves 32-bit range.
   function automatic bit ex_ref(input instr_t i);
`ifdef EX_OVF_EN
      longint x, y, r;
      x = longint'($signed(i.a));
      y = longint'($signed(i.b));
      if (!i.ovf || i.op > 1) return 1'b0;
      r = (i.op == 0) ? x + y : x - y;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      return 1'b0;
`endif
   endfunction

   function automatic instr_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rt, input logic [4:0] dest,
                                 input bit ld, input bit st, input bit ovf, input logic [31:0] pc);
      instr_t i;
      i.op = op; i.a = a; i.b = b; i.rt = rt; i.dest = dest;
      i.ld = ld; i.st = st; i.ovf = ovf; i.pc = pc;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int k;
      i.op = $urandom_range(0, 11);
      i.a = $urandom;
      i.b = ($urandom_range(0, 3) == 0) ? 32'h7fffffff : $urandom;
      i.rt = $urandom;
      i.dest = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      k = $urandom_range(0, 3);
      i.ld = (k == 0);
      i.st = (k == 1);
      i.ovf = (i.op <= 1) && ($urandom_range(0, 1) == 1);
      i.pc = {$urandom_range(0, 32'h3fffffff), 2'b00};
      return i;
   endfunction

   task automatic drive(input instr_t i);
      bus.ds_to_es_valid = 1'b1;
      bus.ds_alu_op      = 12'b1 << i.op;
      bus.ds_src1        = i.a;
      bus.ds_src2        = i.b;
      bus.ds_rt_value    = i.rt;
      bus.ds_dest        = i.dest;
      bus.ds_load        = i.ld;
      bus.ds_store       = i.st;
      bus.ds_ovf_chk     = i.ovf;
      bus.ds_pc          = i.pc;
   endtask

   task automatic idle();
      bus.ds_to_es_valid = 1'b0;
      bus.ds_alu_op      = $urandom;
      bus.ds_src1        = $urandom;
      bus.ds_src2        = $urandom;
      bus.ds_rt_value    = $urandom;
      bus.ds_dest        = 5'($urandom);
      bus.ds_load        = 1'b0;
      bus.ds_store       = 1'b0;
      bus.ds_ovf_chk     = 1'b0;
      bus.ds_pc          = $urandom;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      ms_allowin = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++; if (bus.es_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_allowin got=%b exp=1", bus.es_allowin); end
      n_cmp++; if (es_to_ms_valid !== 1'b0) begin n_bad++; $display("FAIL rst_to_ms_valid got=%b exp=0", es_to_ms_valid); end
      n_cmp++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0) begin n_bad++; $display("FAIL rst_sram got en=%b wen=%h exp 0/0", data_sram_en, data_sram_wen); end
      n_cmp++; if (es_fwd_valid !== 1'b0 || es_ex !== 1'b0) begin n_bad++; $display("FAIL rst_fwd_ex got fwd=%b ex=%b exp 0/0", es_fwd_valid, es_ex); end
      n_cmp++; if (es_result !== 32'h0 || es_pc !== 32'h0 || es_dest !== 5'd0) begin n_bad++; $display("FAIL rst_payload got res=%h pc=%h dest=%0d exp 0", es_result, es_pc, es_dest); end
   endtask

   task automatic test_add_handoff();
      @(negedge clk);
      ms_allowin = 1'b1;
      drive(mk(0, 32'h7, 32'h9, 32'h0, 5'd5, 0, 0, 0, 32'hbfc0_0000));
      @(posedge clk);
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (es_to_ms_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got=%b exp=1", es_to_ms_valid); end
      n_cmp++; if (es_result !== 32'h10) begin n_bad++; $display("FAIL add_result got=%h exp=00000010", es_result); end
      n_cmp++; if (es_fwd_valid !== 1'b1 || es_fwd_dest !== 5'd5) begin n_bad++; $display("FAIL add_fwd got v=%b d=%0d exp 1/5", es_fwd_valid, es_fwd_dest); end
      n_cmp++; if (es_pc !== 32'hbfc0_0000 || data_sram_en !== 1'b0) begin n_bad++; $display("FAIL add_pc_en got pc=%h en=%b", es_pc, data_sram_en); end
      @(posedge clk);
   endtask

   task automatic test_stalled_store();
      @(negedge clk);
      ms_allowin = 1'b0;
      drive(mk(0, 32'h100, 32'h4, 32'hdeadbeef, 5'd0, 0, 1, 0, 32'h100));
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle();
         #1;
         n_cmp++; if (data_sram_en !== 1'b0 || bus.es_allowin !== 1'b0 || es_to_ms_valid !== 1'b1) begin
            n_bad++; $display("FAIL st_stall%0d got en=%b allowin=%b valid=%b exp 0/0/1", c, data_sram_en, bus.es_allowin, es_to_ms_valid);
         end
         @(posedge clk);
      end
      @(negedge clk);
      ms_allowin = 1'b1;
      #1;
      n_cmp++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'hf) begin n_bad++; $display("FAIL st_issue got en=%b wen=%h exp 1/f", data_sram_en, data_sram_wen); end
      n_cmp++; if (data_sram_addr !== 32'h104 || data_sram_wdata !== 32'hdeadbeef) begin n_bad++; $display("FAIL st_addr_data got a=%h d=%h exp 00000104/deadbeef", data_sram_addr, data_sram_wdata); end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (data_sram_en !== 1'b0 || es_to_ms_valid !== 1'b0) begin n_bad++; $display("FAIL st_oneshot got en=%b valid=%b exp 0/0", data_sram_en, es_to_ms_valid); end
   endtask

   task automatic test_back_to_back();
      instr_t seq [4];
      for (int k = 0; k < 4; k++) begin
         seq[k] = rand_instr();
         seq[k].ld = 0; seq[k].st = 0; seq[k].ovf = 0;
      end
      ms_allowin = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k < 4) drive(seq[k]); else idle();
         #1;
         n_cmp++; if (bus.es_allowin !== 1'b1) begin n_bad++; $display("FAIL b2b_allowin%0d got=%b exp=1", k, bus.es_allowin); end
         if (k > 0) begin
            n_cmp++; if (es_to_ms_valid !== 1'b1 || es_result !== alu_ref(seq[k-1]) || es_pc !== seq[k-1].pc) begin
               n_bad++; $display("FAIL b2b_out%0d got v=%b res=%h pc=%h exp 1/%h/%h", k-1, es_to_ms_valid, es_result, es_pc, alu_ref(seq[k-1]), seq[k-1].pc);
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic test_load_hazard();
      @(negedge clk);
      ms_allowin = 1'b1;
      drive(mk(0, 32'h2000, 32'h10, 32'h0, 5'd8, 1, 0, 0, 32'h200));
      @(posedge clk);
      @(negedge clk);
      drive(mk(6, 32'h1, 32'h2, 32'h0, 5'd0, 0, 0, 0, 32'h204));
      #1;
      n_cmp++; if (es_fwd_is_load !== 1'b1 || es_fwd_valid !== 1'b1 || es_fwd_dest !== 5'd8) begin n_bad++; $display("FAIL lw_fwd got ld=%b v=%b d=%0d exp 1/1/8", es_fwd_is_load, es_fwd_valid, es_fwd_dest); end
      n_cmp++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'h0 || data_sram_addr !== 32'h2010) begin n_bad++; $display("FAIL lw_sram got en=%b wen=%h a=%h exp 1/0/00002010", data_sram_en, data_sram_wen, data_sram_addr); end
      n_cmp++; if (es_load !== 1'b1) begin n_bad++; $display("FAIL lw_es_load got=%b exp=1", es_load); end
      @(posedge clk);
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (es_to_ms_valid !== 1'b1 || es_fwd_valid !== 1'b0 || es_fwd_is_load !== 1'b0) begin n_bad++; $display("FAIL dest0_fwd got v=%b fwd=%b ld=%b exp 1/0/0", es_to_ms_valid, es_fwd_valid, es_fwd_is_load); end
      @(posedge clk);
   endtask

   task automatic test_overflow();
      @(negedge clk);
      ms_allowin = 1'b1;
      drive(mk(0, 32'h7fffffff, 32'h1, 32'h0, 5'd3, 0, 0, 1, 32'h300));
      @(posedge clk);
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (es_to_ms_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got=%b exp=1", es_to_ms_valid); end
`ifdef EX_OVF_EN
      n_cmp++; if (es_ex !== 1'b1 || es_dest !== 5'd0 || es_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_ex got ex=%b dest=%0d fwd=%b exp 1/0/0", es_ex, es_dest, es_fwd_valid); end
`else
      n_cmp++; if (es_result !== 32'h80000000 || es_ex !== 1'b0 || es_dest !== 5'd3) begin n_bad++; $display("FAIL ovf_wrap got res=%h ex=%b dest=%0d exp 80000000/0/3", es_result, es_ex, es_dest); end
`endif
      @(posedge clk);
   endtask

   task automatic test_reset_mid_stall();
      int issued = 0;
      @(negedge clk);
      ms_allowin = 1'b0;
      drive(mk(0, 32'h400, 32'h0, 32'h12345678, 5'd0, 0, 1, 0, 32'h400));
      @(posedge clk);
      @(negedge clk);
      idle();
      resetn = 1'b0;
      #1;
      if (data_sram_en === 1'b1) issued++;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      ms_allowin = 1'b1;
      #1;
      n_cmp++; if (es_to_ms_valid !== 1'b0 || bus.es_allowin !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid got v=%b allowin=%b exp 0/1", es_to_ms_valid, bus.es_allowin); end
      for (int c = 0; c < 4; c++) begin
         if (data_sram_en === 1'b1) issued++;
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      n_cmp++; if (issued !== 0) begin n_bad++; $display("FAIL rstmid_store got %0d requests exp 0", issued); end
   endtask

   task automatic test_random();
      instr_t cur, nxt;
      bit held = 0;
      bit dv;
      bit exp_ex, exp_mem;
      logic [4:0] exp_dest;
      logic [31:0] exp_res;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         ms_allowin = ($urandom_range(0, 3) != 0);
         dv = ($urandom_range(0, 4) != 0);
         nxt = rand_instr();
         if (dv) drive(nxt); else idle();
         #1;
         n_cmp++; if (es_to_ms_valid !== held || bus.es_allowin !== (!held || ms_allowin)) begin
            n_bad++; $display("FAIL rnd_hs c=%0d got v=%b allowin=%b exp %b/%b", c, es_to_ms_valid, bus.es_allowin, held, !held || ms_allowin);
         end
         if (held) begin
            exp_res  = alu_ref(cur);
            exp_ex   = ex_ref(cur);
            exp_dest = exp_ex ? 5'd0 : cur.dest;
            exp_mem  = ms_allowin && (cur.ld || cur.st) && !exp_ex;
            n_cmp++; if (es_result !== exp_res || es_fwd_data !== exp_res || es_pc !== cur.pc) begin
               n_bad++; $display("FAIL rnd_res c=%0d op=%0d got res=%h fwd=%h pc=%h exp %h/%h", c, cur.op, es_result, es_fwd_data, es_pc, exp_res, cur.pc);
            end
            n_cmp++; if (es_ex !== exp_ex || es_dest !== exp_dest || es_load !== cur.ld) begin
               n_bad++; $display("FAIL rnd_ctl c=%0d got ex=%b dest=%0d ld=%b exp %b/%0d/%b", c, es_ex, es_dest, es_load, exp_ex, exp_dest, cur.ld);
            end
            n_cmp++; if (es_fwd_valid !== (exp_dest != 0) || es_fwd_dest !== exp_dest || es_fwd_is_load !== ((exp_dest != 0) && cur.ld)) begin
               n_bad++; $display("FAIL rnd_fwd c=%0d got v=%b d=%0d ld=%b exp dest %0d", c, es_fwd_valid, es_fwd_dest, es_fwd_is_load, exp_dest);
            end
            n_cmp++; if (data_sram_en !== exp_mem || data_sram_wen !== ((exp_mem && cur.st) ? 4'hf : 4'h0)) begin
               n_bad++; $display("FAIL rnd_sram c=%0d got en=%b wen=%h exp en=%b", c, data_sram_en, data_sram_wen, exp_mem);
            end
            if (exp_mem) begin
               n_cmp++; if (data_sram_addr !== exp_res || data_sram_wdata !== cur.rt) begin
                  n_bad++; $display("FAIL rnd_addr c=%0d got a=%h d=%h exp %h/%h", c, data_sram_addr, data_sram_wdata, exp_res, cur.rt);
               end
            end
         end else begin
            n_cmp++; if (data_sram_en !== 1'b0 || es_fwd_valid !== 1'b0) begin
               n_bad++; $display("FAIL rnd_empty c=%0d got en=%b fwd=%b exp 0/0", c, data_sram_en, es_fwd_valid);
            end
         end
         if (!held || ms_allowin) begin
            held = dv;
            if (dv) cur = nxt;
         end
         @(posedge clk);
      end
      @(negedge clk);
      idle();
      ms_allowin = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      idle();
      test_reset();
      test_add_handoff();
      test_stalled_store();
      test_back_to_back();
      test_load_hazard();
      test_overflow();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
